pixel_fetch: RTL and testbench

- Answers single-pixel requests from the circle-centre search stage.
- Per request: latches the (x,y) coordinate, reads the 8-bit greyscale pixel from the frame-buffer read port, thresholds it to one bit, and returns the bit with a one-cycle valid pulse.
- Sits directly upstream of the centre finder: drives its rec_data / rec_data_vaild inputs and consumes its req_adr_x / req_adr_y / req_valid outputs.

---
 rtl/pixel_fetch_if.sv | 28 ++
 rtl/pixel_fetch.sv | 135 +++++++++++++
 tb/tb_pixel_fetch.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// Request/response and frame-buffer read signals between the centre finder,
// the frame buffer and pixel_fetch.
interface pixel_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic [9:0]        req_adr_x;
  logic [9:0]        req_adr_y;
  logic              req_valid;
  logic [PIX_W-1:0]  thresh;
  logic              rec_data;
  logic              rec_data_vaild;
  logic              req_oob;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rd_data;

  modport slave (
    input  req_adr_x, req_adr_y, req_valid, thresh, mem_rd_data,
    output rec_data, rec_data_vaild, req_oob, busy, mem_rd_en, mem_addr
  );

  modport master (
    output req_adr_x, req_adr_y, req_valid, thresh, mem_rd_data,
    input  rec_data, rec_data_vaild, req_oob, busy, mem_rd_en, mem_addr
  );
endinterface

// File: rtl/pixel_fetch.sv
// Single-pixel fetch for the circle-centre search: reads one greyscale pixel
// per request and returns it thresholded to one bit with a one-cycle pulse.
module pixel_fetch #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int ADDR_W      = 19,
  parameter int PIX_W       = 8,
  parameter int RD_LAT      = 1,
  parameter int DARK_IS_ONE = 1
) (
  input  logic         clk,
  input  logic         rst,
  pixel_fetch_if.slave bus
);
  localparam int          CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [31:0] IMG_W_U  = 32'(IMG_W);
  localparam logic [31:0] IMG_H_U  = 32'(IMG_H);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAITRD, RESP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic [PIX_W-1:0]  thresh_q, thresh_d;
  logic              oob_q, oob_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rec_data_q, rec_data_d;
  logic              rec_vld_q, rec_vld_d;
  logic              req_oob_q, req_oob_d;
  logic              busy_q, busy_d;

  // Unsigned compare; a pixel equal to the threshold counts as bright.
  function automatic logic binarise(input logic [PIX_W-1:0] pix,
                                    input logic [PIX_W-1:0] th);
    if (DARK_IS_ONE != 0) return (pix < th);
    else                  return (pix >= th);
  endfunction

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    thresh_d    = thresh_q;
    oob_d       = oob_q;
    cnt_d       = cnt_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    rec_data_d  = rec_data_q;
    rec_vld_d   = 1'b0;
    req_oob_d   = req_oob_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          x_d      = bus.req_adr_x;
          y_d      = bus.req_adr_y;
          thresh_d = bus.thresh;
          state_d  = CALC;
        end
      end
      CALC: begin
        mem_addr_d = ADDR_W'(y_q) * ADDR_W'(IMG_W) + ADDR_W'(x_q);
        oob_d      = (32'(x_q) >= IMG_W_U) || (32'(y_q) >= IMG_H_U);
        state_d    = ISSUE;
      end
      ISSUE: begin
        // Wrapped search-window coordinates are answered without touching memory.
        if (oob_q) begin
          rec_data_d = 1'b0;
          req_oob_d  = 1'b1;
          rec_vld_d  = 1'b1;
          state_d    = HOLD;
        end else begin
          mem_rd_en_d = 1'b1;
          cnt_d       = CNT_W'(RD_LAT);
          state_d     = WAITRD;
        end
      end
      WAITRD: begin
        if (cnt_q == '0) begin
          rec_data_d = binarise(bus.mem_rd_data, thresh_q);
          req_oob_d  = 1'b0;
          rec_vld_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: state_d = HOLD;
      // A still-asserted level request must not trigger a second read.
      HOLD: if (!bus.req_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      oob_q       <= 1'b0;
      cnt_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rec_data_q  <= 1'b0;
      rec_vld_q   <= 1'b0;
      req_oob_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      oob_q       <= oob_d;
      cnt_q       <= cnt_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rec_data_q  <= rec_data_d;
      rec_vld_q   <= rec_vld_d;
      req_oob_q   <= req_oob_d;
      busy_q      <= busy_d;
    end
  end

  // Request payload is only consumed after acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    x_q      <= x_d;
    y_q      <= y_d;
    thresh_q <= thresh_d;
  end

  assign bus.mem_rd_en      = mem_rd_en_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.rec_data       = rec_data_q;
  assign bus.rec_data_vaild = rec_vld_q;
  assign bus.req_oob        = req_oob_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: frame-buffer model plus a transaction-level reference
// that predicts response timing, read address and thresholded bit per request.
module tb_pixel_fetch;
  localparam int IMG_W  = 640;
  localparam int IMG_H  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 8;
  localparam int RD_LAT = 1;
  localparam int FB_SZ  = IMG_W * IMG_H;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_fetch_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) pf_if   ();
  pixel_fetch_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) pf_if_b ();

  pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
                .RD_LAT(RD_LAT), .DARK_IS_ONE(1)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (pf_if)
  );

  // Second instance with inverted polarity shares all inputs with the first.
  pixel_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .PIX_W(PIX_W),
                .RD_LAT(RD_LAT), .DARK_IS_ONE(0)) dut_b (
    .clk (clk),
    .rst (rst_n),
    .bus (pf_if_b)
  );

  assign pf_if_b.req_adr_x   = pf_if.req_adr_x;
  assign pf_if_b.req_adr_y   = pf_if.req_adr_y;
  assign pf_if_b.req_valid   = pf_if.req_valid;
  assign pf_if_b.thresh      = pf_if.thresh;
  assign pf_if_b.mem_rd_data = pf_if.mem_rd_data;

  // Frame buffer: data is valid for exactly one cycle, garbage otherwise.
  logic [7:0] fb      [FB_SZ];
  logic [7:0] rd_pipe [RD_LAT];
  int         rd_cnt = 0;

  always @(posedge clk) begin
    if (pf_if.mem_rd_en && (32'(pf_if.mem_addr) < FB_SZ))
      rd_pipe[0] <= fb[pf_if.mem_addr];
    else
      rd_pipe[0] <= 8'($urandom);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (pf_if.mem_rd_en) rd_cnt <= rd_cnt + 1;
  end
  assign pf_if.mem_rd_data = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_errors = 0;
  int ones_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"},  pf_if.rec_data_vaild, 0);
    check_val({tag, "_rd_en"},  pf_if.mem_rd_en, 0);
    check_val({tag, "_busy"},   pf_if.busy, 0);
    check_val({tag, "_data"},   pf_if.rec_data, 0);
    check_val({tag, "_oob"},    pf_if.req_oob, 0);
    check_val({tag, "_addr"},   pf_if.mem_addr, 0);
    check_val({tag, "_b_busy"}, pf_if_b.busy, 0);
  endtask

  // One request; called at a negedge with the DUT idle, returns at a negedge
  // with the DUT idle again. drop_k: negedge index (after E0) at which
  // req_valid is released.
  task automatic do_req(input int x, input int y, input int th, input int drop_k);
    bit oob;
    int addr, pix, exp_bit, exp_bit_b, vk, hk, ik, rd0;
    oob  = (x >= IMG_W) || (y >= IMG_H);
    addr = y * IMG_W + x;
    pix  = 0;
    if (!oob) pix = int'(fb[addr]);
    exp_bit   = oob ? 0 : int'(pix <  th);
    exp_bit_b = oob ? 0 : int'(pix >= th);
    vk  = oob ? 2 : 3 + RD_LAT;           // valid visible after edge E(vk)
    hk  = oob ? vk : vk + 1;              // HOLD entered at edge E(hk)
    ik  = ((hk > drop_k) ? hk : drop_k) + 1;
    rd0 = rd_cnt;
    pf_if.req_adr_x = 10'(x);
    pf_if.req_adr_y = 10'(y);
    pf_if.thresh    = 8'(th);
    pf_if.req_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= ik; k++) begin
      @(negedge clk);
      check_val("valid", pf_if.rec_data_vaild, 32'(k == vk));
      check_val("busy",  pf_if.busy, 32'(k < ik));
      check_val("rd_en", pf_if.mem_rd_en, 32'(!oob && k == 2));
      if (!oob && k == 2) check_val("mem_addr", pf_if.mem_addr, addr);
      if (k == vk || k == ik) begin
        check_val("rec_data",   pf_if.rec_data, exp_bit);
        check_val("req_oob",    pf_if.req_oob, 32'(oob));
        check_val("rec_data_b", pf_if_b.rec_data, exp_bit_b);
      end
      if (k == vk) begin
        check_val("valid_b", pf_if_b.rec_data_vaild, 1);
        if (pf_if.rec_data_vaild && pf_if.rec_data) ones_cnt++;
      end
      if (k == drop_k) pf_if.req_valid = 1'b0;
    end
    check_val("reads", rd_cnt - rd0, oob ? 0 : 1);
  endtask

  initial begin
    int disc_cnt;
    pf_if.req_adr_x = '0;
    pf_if.req_adr_y = '0;
    pf_if.req_valid = 1'b0;
    pf_if.thresh    = '0;
    for (int i = 0; i < FB_SZ; i++) fb[i] = 8'd220;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // In-bounds dark, bright, equal pixels at (100,50)
    fb[32100] = 8'd40;  do_req(100, 50, 128, 0);
    fb[32100] = 8'd200; do_req(100, 50, 128, 0);
    fb[32100] = 8'd128; do_req(100, 50, 128, 0);

    // Wrapped and image-edge coordinates
    do_req(1021, 10, 128, 0);
    do_req(639, 480, 128, 0);
    fb[307199] = 8'd7;  do_req(639, 479, 128, 0);
    do_req(1023, 1023, 0, 0);

    // Level-held request, and a request dropped mid-operation
    fb[32100] = 8'd40;  do_req(100, 50, 128, 3 + RD_LAT + 20);
    do_req(1019, 5, 128, 22);
    fb[0] = 8'd255;     do_req(0, 0, 255, 1);

    // Reset asserted while waiting for read data
    fb[32100] = 8'd40;
    pf_if.req_adr_x = 10'd100;
    pf_if.req_adr_y = 10'd50;
    pf_if.thresh    = 8'd128;
    pf_if.req_valid = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    pf_if.req_valid = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_val("post_rst_valid", pf_if.rec_data_vaild, 0);
      check_val("post_rst_busy",  pf_if.busy, 0);
    end
    do_req(100, 50, 128, 0);

    // Randomised requests against the model
    for (int n = 0; n < 80; n++) begin
      int x, y, th, p;
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, IMG_W - 1);
        y = $urandom_range(0, IMG_H - 1);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 1023);
      end
      th = $urandom_range(0, 255);
      p  = ($urandom_range(0, 3) == 0) ? th : $urandom_range(0, 255);
      if (x < IMG_W && y < IMG_H) fb[y * IMG_W + x] = 8'(p);
      do_req(x, y, th, $urandom_range(0, 10));
    end

    // Centre-finder emulation: 21x21 window over a radius-7 disc
    disc_cnt = 0;
    for (int dy = -10; dy <= 10; dy++)
      for (int dx = -10; dx <= 10; dx++) begin
        bit in_disc;
        in_disc = (dx * dx + dy * dy) <= 49;
        fb[(240 + dy) * IMG_W + (320 + dx)] = in_disc ? 8'd20 : 8'd220;
        if (in_disc) disc_cnt++;
      end
    ones_cnt = 0;
    for (int dy = -10; dy <= 10; dy++)
      for (int dx = -10; dx <= 10; dx++)
        do_req(320 + dx, 240 + dy, 128, 0);
    check_val("disc_ones", ones_cnt, disc_cnt);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
